// File: rtl/dff_univ_shift_reg.sv
// Universal WIDTH-bit shift register: direct load/preset/clear/shift/rotate ops
// plus an autonomous burst-shift engine driven by a single start pulse.
module dff_univ_shift_reg #(
    parameter int unsigned        WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int unsigned       CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_SHL    = 3'b010;
    localparam logic [2:0] MODE_SHR    = 3'b011;
    localparam logic [2:0] MODE_ROTL   = 3'b100;
    localparam logic [2:0] MODE_ROTR   = 3'b101;
    localparam logic [2:0] MODE_PRESET = 3'b110;
    localparam logic [2:0] MODE_CLEAR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] rem, rem_next;
    logic             dir_q, dir_next;
    logic [WIDTH-1:0] q_next;
    logic             sout_next;
    logic [CNT_W-1:0] sat_count;

    // Burst length clamped to the register width.
    assign sat_count = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

    // State, burst bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rem   <= '0;
            dir_q <= 1'b0;
            q     <= RESET_VAL;
            sout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            dir_q <= dir_next;
            q     <= q_next;
            sout  <= sout_next;
            busy  <= (state_next == S_SHIFT);
            done  <= (state_next == S_DONE);
        end
    end

    // Next-state, burst counter and datapath selection.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        dir_next   = dir_q;
        q_next     = q;
        sout_next  = sout;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    // start pre-empts any direct op on this edge; no shift happens yet
                    dir_next   = dir;
                    rem_next   = sat_count;
                    state_next = (sat_count == '0) ? S_DONE : S_SHIFT;
                end else if (en) begin
                    unique case (mode)
                        MODE_HOLD: ;
                        MODE_LOAD: q_next = d;
                        MODE_SHL: begin
                            q_next    = {q[WIDTH-2:0], sin};
                            sout_next = q[WIDTH-1];
                        end
                        MODE_SHR: begin
                            q_next    = {sin, q[WIDTH-1:1]};
                            sout_next = q[0];
                        end
                        MODE_ROTL: begin
                            q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                            sout_next = q[WIDTH-1];
                        end
                        MODE_ROTR: begin
                            q_next    = {q[0], q[WIDTH-1:1]};
                            sout_next = q[0];
                        end
                        MODE_PRESET: q_next = '1;
                        MODE_CLEAR:  q_next = '0;
                        default: ;
                    endcase
                end
            end

            S_SHIFT: begin
                if (dir_q) begin
                    q_next    = {sin, q[WIDTH-1:1]};
                    sout_next = q[0];
                end else begin
                    q_next    = {q[WIDTH-2:0], sin};
                    sout_next = q[WIDTH-1];
                end
                rem_next = rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
